// File: rtl/noc_ingress_arb.sv
// -----------------------------------------------------------------------------
// noc_ingress_arb
//
// Purpose:
//   Ingress stage of the NoC. Merges CPU_NB per-CPU valid/ready streams into
//   one ordered output stream. Each CPU feeds a small private FIFO; a
//   round-robin arbiter picks among the non-empty FIFOs and loads a single
//   registered output stage, tagging each word with its source CPU index.
//
// Parameters:
//   CPU_NB     - number of CPU input ports (>= 2)
//   DATA_W     - payload width
//   FIFO_DEPTH - entries per input FIFO (>= 2, power of two)
//   SRC_W      - width of the source index, derived from CPU_NB
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst      in   synchronous active-high reset
//   in_vld   in   [CPU_NB]          per-CPU data valid
//   in_rdy   out  [CPU_NB]          per-CPU ready (FIFO has room, not in reset)
//   in_data  in   [CPU_NB][DATA_W]  per-CPU payload
//   out_vld  out  output word valid
//   out_rdy  in   downstream ready
//   out_data out  [DATA_W]          output payload
//   out_src  out  [SRC_W]           CPU index that produced out_data
//   out_cnt  out  [32]              words delivered, modulo 2^32
// -----------------------------------------------------------------------------
module noc_ingress_arb #(
  parameter  int CPU_NB     = 4,
  parameter  int DATA_W     = 64,
  parameter  int FIFO_DEPTH = 2,
  localparam int SRC_W      = $clog2(CPU_NB)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CPU_NB-1:0]             in_vld,
  output logic [CPU_NB-1:0]             in_rdy,
  input  logic [CPU_NB-1:0][DATA_W-1:0] in_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_W-1:0]             out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic [31:0]                   out_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Round-robin pick: first requester after 'last', wrapping modulo CPU_NB.
  // Returns {found, index}; index is zero when nothing is requesting.
  function automatic logic [SRC_W:0] rr_pick(input logic [CPU_NB-1:0] req,
                                             input logic [SRC_W-1:0]  last);
    logic             found;
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] cand;
    found = 1'b0;
    idx   = {SRC_W{1'b0}};
    for (int k = 1; k <= CPU_NB; k++) begin
      cand = SRC_W'((int'(last) + k) % CPU_NB);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Per-CPU FIFO state
  logic [DATA_W-1:0] mem_q    [CPU_NB][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [CPU_NB];
  logic [PTR_W-1:0]  wr_ptr_d [CPU_NB];
  logic [PTR_W-1:0]  rd_ptr_q [CPU_NB];
  logic [PTR_W-1:0]  rd_ptr_d [CPU_NB];
  logic [CNT_W-1:0]  fcnt_q   [CPU_NB];
  logic [CNT_W-1:0]  fcnt_d   [CPU_NB];

  // Output stage and arbiter state
  logic              out_vld_q,    out_vld_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic [SRC_W-1:0]  out_src_q,    out_src_d;
  logic [31:0]       out_cnt_q,    out_cnt_d;
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;

  // Combinational helpers
  logic [CPU_NB-1:0] rdy_s;
  logic [CPU_NB-1:0] nempty_s;
  logic [CPU_NB-1:0] push_s;
  logic [CPU_NB-1:0] pop_s;
  logic              load_s;
  logic              gnt_vld_s;
  logic [SRC_W-1:0]  gnt_idx_s;
  logic [DATA_W-1:0] head_s;

  // FIFO status: ready comes only from registered occupancy (and reset), so
  // there is no combinational path from in_vld or out_rdy to in_rdy.
  always_comb begin
    rdy_s    = {CPU_NB{1'b0}};
    nempty_s = {CPU_NB{1'b0}};
    for (int i = 0; i < CPU_NB; i++) begin
      rdy_s[i]    = !rst && (fcnt_q[i] < CNT_W'(FIFO_DEPTH));
      nempty_s[i] = (fcnt_q[i] != {CNT_W{1'b0}});
    end
  end

  assign push_s = in_vld & rdy_s;

  // Arbitration: the output register may load when empty or being drained.
  always_comb begin
    load_s                 = !out_vld_q || out_rdy;
    {gnt_vld_s, gnt_idx_s} = rr_pick(nempty_s, last_grant_q);
    head_s                 = mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];
    pop_s                  = {CPU_NB{1'b0}};
    if (load_s && gnt_vld_s) begin
      pop_s[gnt_idx_s] = 1'b1;
    end else begin
      pop_s = {CPU_NB{1'b0}};
    end
  end

  // FIFO next state: pointers advance on push/pop; simultaneous push and pop
  // leaves the occupancy unchanged.
  always_comb begin
    for (int i = 0; i < CPU_NB; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      fcnt_d[i]   = fcnt_q[i];
      if (push_s[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
        2'b01:   fcnt_d[i] = fcnt_q[i] - CNT_W'(1);
        default: fcnt_d[i] = fcnt_q[i];
      endcase
    end
  end

  // Output register next state; data/src hold when nothing is granted.
  always_comb begin
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    out_cnt_d    = out_cnt_q;
    if (load_s) begin
      if (gnt_vld_s) begin
        out_vld_d    = 1'b1;
        out_data_d   = head_s;
        out_src_d    = gnt_idx_s;
        last_grant_d = gnt_idx_s;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      out_vld_d = out_vld_q;
    end
    if (out_vld_q && out_rdy) begin
      out_cnt_d = out_cnt_q + 32'd1;
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // FIFO storage: written only on accepted pushes, which reset already blocks.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_NB; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

  // FIFO control registers with synchronous reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_NB; i++) begin
      if (rst) begin
        wr_ptr_q[i] <= {PTR_W{1'b0}};
        rd_ptr_q[i] <= {PTR_W{1'b0}};
        fcnt_q[i]   <= {CNT_W{1'b0}};
      end else begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        fcnt_q[i]   <= fcnt_d[i];
      end
    end
  end

  // Output stage, round-robin pointer and delivery counter. last_grant resets
  // to the highest index so CPU 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      out_src_q    <= {SRC_W{1'b0}};
      out_cnt_q    <= 32'd0;
      last_grant_q <= SRC_W'(CPU_NB - 1);
    end else begin
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_cnt_q    <= out_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign in_rdy   = rdy_s;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;
  assign out_cnt  = out_cnt_q;

endmodule

// File: tb/tb_noc_ingress_arb.sv
// -----------------------------------------------------------------------------
// tb_noc_ingress_arb
//
// Directed testbench for noc_ingress_arb (CPU_NB=4, DATA_W=64, FIFO_DEPTH=2).
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// 2 time units after it, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_noc_ingress_arb;

  localparam int N = 4;
  localparam int W = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         in_vld;
  logic [N-1:0]         in_rdy;
  logic [N-1:0][W-1:0]  in_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [W-1:0]         out_data;
  logic [1:0]           out_src;
  logic [31:0]          out_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  noc_ingress_arb #(.CPU_NB(N), .DATA_W(W), .FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_src  (out_src),
    .out_cnt  (out_cnt)
  );

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_vld  = 4'b0000;
    out_rdy = 1'b0;
    in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    in_vld  = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = {8'(i), 56'h5};
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      vectors++;
      if (in_rdy !== 4'b0000 || out_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold c%0d: in_rdy=%b out_vld=%b, expected 0000/0", c, in_rdy, out_vld);
      end
    end
    vectors++;
    if (out_cnt !== 32'd0 || out_data !== 64'd0 || out_src !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_values: cnt=%0d data=%h src=%0d, expected 0/0/0", out_cnt, out_data, out_src);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_rdy !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_release_rdy: in_rdy=%b, expected 1111", in_rdy);
    end
    tick();
    in_vld = 4'b0000;
    #1;
    vectors++;
    if (out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_latency: out_vld=%b one edge after accept, expected 0", out_vld);
    end
    tick();
    #1;
    vectors++;
    if (out_vld !== 1'b1 || out_src !== 2'd0 || out_data !== {8'd0, 56'h5}) begin
      miscompares++;
      $display("FAIL reset_first_grant: vld=%b src=%0d data=%h, expected 1/0/%h",
               out_vld, out_src, out_data, {8'd0, 56'h5});
    end
  endtask

  task automatic test_contention();
    int         seq [N];
    int         dseq[N];
    int         ndel[N];
    int         exp_src;
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; dseq[i] = 0; ndel[i] = 0;
    end
    exp_src = 0;
    do_reset();
    out_rdy = 1'b1;
    in_vld  = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) in_data[i] = {8'(i), 56'(seq[i])};
      #1;
      if (c >= 2) begin
        vectors++;
        if (out_vld !== 1'b1) begin
          miscompares++;
          $display("FAIL contention_rate c%0d: out_vld=%b, expected 1", c, out_vld);
        end
      end
      if (out_vld === 1'b1) begin
        vectors++;
        if (out_src !== 2'(exp_src) || out_data !== {8'(exp_src), 56'(dseq[exp_src])}) begin
          miscompares++;
          $display("FAIL contention_order c%0d: src=%0d data=%h, expected src=%0d data=%h",
                   c, out_src, out_data, exp_src, {8'(exp_src), 56'(dseq[exp_src])});
        end
        ndel[out_src]++;
        dseq[exp_src]++;
        exp_src = (exp_src + 1) % N;
      end
      acc = in_vld & in_rdy;
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    end
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (ndel[i] < 99 || ndel[i] > 101) begin
        miscompares++;
        $display("FAIL contention_fair cpu%0d: delivered %0d, expected 100+-1", i, ndel[i]);
      end
    end
  endtask

  task automatic test_single_source();
    int nxt, exp, ndel, first_acc, first_vld;
    logic acc;
    nxt = 1; exp = 1; ndel = 0; first_acc = -1; first_vld = -1;
    do_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_vld     = (nxt <= 32) ? 4'b0100 : 4'b0000;
      in_data[2] = 64'(nxt);
      #1;
      vectors++;
      if (in_rdy[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL single_rdy c%0d: in_rdy[2]=%b, expected 1", c, in_rdy[2]);
      end
      if (first_vld >= 0 && ndel < 32) begin
        vectors++;
        if (out_vld !== 1'b1) begin
          miscompares++;
          $display("FAIL single_gap c%0d: out_vld=%b, expected 1", c, out_vld);
        end
      end
      if (out_vld === 1'b1) begin
        if (first_vld < 0) first_vld = c;
        vectors++;
        if (out_src !== 2'd2 || out_data !== 64'(exp)) begin
          miscompares++;
          $display("FAIL single_data c%0d: src=%0d data=%h, expected src=2 data=%h", c, out_src, out_data, 64'(exp));
        end
        exp++;
        ndel++;
      end
      acc = in_vld[2] && in_rdy[2];
      if (acc && first_acc < 0) first_acc = c;
      tick();
      if (acc) nxt++;
    end
    vectors++;
    if (first_acc < 0 || first_vld != first_acc + 2) begin
      miscompares++;
      $display("FAIL single_latency: first out_vld slot %0d, expected %0d", first_vld, first_acc + 2);
    end
    vectors++;
    if (ndel != 32) begin
      miscompares++;
      $display("FAIL single_count: delivered %0d, expected 32", ndel);
    end
  endtask

  task automatic test_backpressure();
    int nacc, exp, ndel;
    nacc = 0; exp = 0; ndel = 0;
    do_reset();
    out_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_vld     = 4'b0010;
      in_data[1] = 64'hA0 + 64'(nacc);
      #1;
      if (out_vld === 1'b1) begin
        vectors++;
        if (out_data !== 64'hA0 || out_src !== 2'd1) begin
          miscompares++;
          $display("FAIL bp_hold c%0d: data=%h src=%0d, expected 00a0/1", c, out_data, out_src);
        end
      end
      if (in_rdy[1] === 1'b1) nacc++;
      tick();
    end
    #1;
    vectors++;
    if (nacc != 3 || in_rdy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_capacity: accepted %0d in_rdy[1]=%b, expected 3/0", nacc, in_rdy[1]);
    end
    vectors++;
    if (out_vld !== 1'b1 || out_data !== 64'hA0) begin
      miscompares++;
      $display("FAIL bp_stable: vld=%b data=%h, expected 1/00a0", out_vld, out_data);
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_vld     = (nacc < 10) ? 4'b0010 : 4'b0000;
      in_data[1] = 64'hA0 + 64'(nacc);
      #1;
      if (out_vld === 1'b1) begin
        vectors++;
        if (out_data !== 64'hA0 + 64'(exp)) begin
          miscompares++;
          $display("FAIL bp_drain c%0d: data=%h, expected %h", c, out_data, 64'hA0 + 64'(exp));
        end
        exp++;
        ndel++;
      end
      if (in_vld[1] && in_rdy[1]) nacc++;
      tick();
    end
    vectors++;
    if (ndel != 10) begin
      miscompares++;
      $display("FAIL bp_count: delivered %0d, expected 10", ndel);
    end
  endtask

  task automatic test_reset_mid();
    int           dcount, ndel;
    logic [N-1:0] pend;
    dcount = 0; ndel = 0;
    do_reset();
    in_vld = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i] = {16'hDEAD, 48'(i)};
    for (int c = 0; c < 9; c++) begin
      out_rdy = (c < 3) ? 1'b1 : 1'b0;
      #1;
      if (out_vld === 1'b1 && out_rdy) dcount++;
      tick();
    end
    #1;
    vectors++;
    if (out_cnt !== 32'(dcount) || out_vld !== 1'b1 || in_rdy !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_prefill: cnt=%0d vld=%b in_rdy=%b, expected %0d/1/0000", out_cnt, out_vld, in_rdy, dcount);
    end
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    in_vld = 4'b0000;
    #1;
    vectors++;
    if (out_vld !== 1'b0 || out_cnt !== 32'd0 || in_rdy !== 4'b1111) begin
      miscompares++;
      $display("FAIL mid_post_reset: vld=%b cnt=%0d in_rdy=%b, expected 0/0/1111", out_vld, out_cnt, in_rdy);
    end
    pend    = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = 64'h100 + 64'(i);
    for (int c = 0; c < 12; c++) begin
      in_vld = pend;
      #1;
      if (out_vld === 1'b1) begin
        vectors++;
        if (out_data !== 64'h100 + 64'(out_src)) begin
          miscompares++;
          $display("FAIL mid_stale_data: src=%0d data=%h, expected %h", out_src, out_data, 64'h100 + 64'(out_src));
        end
        if (ndel == 0) begin
          vectors++;
          if (out_src !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_first_grant: src=%0d, expected 0", out_src);
          end
        end
        ndel++;
      end
      pend = pend & ~(in_vld & in_rdy);
      tick();
    end
    vectors++;
    if (ndel != 4) begin
      miscompares++;
      $display("FAIL mid_count: delivered %0d, expected 4", ndel);
    end
  endtask

  task automatic test_count_skip();
    int           seq [N];
    int           dseq[N];
    int           ndel, exp_src;
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; dseq[i] = 0;
    end
    ndel = 0; exp_src = 0;
    do_reset();
    for (int c = 0; c < 2000 && ndel < 100; c++) begin
      in_vld     = {seq[3] < 50, 2'b00, seq[0] < 50};
      in_data[0] = {8'd0, 56'(seq[0])};
      in_data[3] = {8'd3, 56'(seq[3])};
      out_rdy    = 1'($urandom_range(1));
      #1;
      if (out_vld === 1'b1 && out_rdy) begin
        vectors++;
        if (out_src !== 2'(exp_src) || out_data !== {8'(exp_src), 56'(dseq[exp_src])}) begin
          miscompares++;
          $display("FAIL skip_order n%0d: src=%0d data=%h, expected src=%0d data=%h",
                   ndel, out_src, out_data, exp_src, {8'(exp_src), 56'(dseq[exp_src])});
        end
        dseq[exp_src]++;
        exp_src = (exp_src == 0) ? 3 : 0;
        ndel++;
      end
      acc = in_vld & in_rdy;
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    end
    out_rdy = 1'b0;
    in_vld  = 4'b0000;
    #1;
    vectors++;
    if (ndel != 100) begin
      miscompares++;
      $display("FAIL skip_timeout: delivered %0d, expected 100", ndel);
    end
    vectors++;
    if (out_cnt !== 32'd100) begin
      miscompares++;
      $display("FAIL skip_out_cnt: out_cnt=%0d, expected 100", out_cnt);
    end
  endtask

  initial begin
    rst     = 1'b1;
    in_vld  = 4'b0000;
    out_rdy = 1'b0;
    in_data = '0;
    test_reset();
    test_contention();
    test_single_source();
    test_backpressure();
    test_reset_mid();
    test_count_skip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
